// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state and sensor-code definitions for the gate sensor
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    ERR
  } gate_state_t;

  // Sensor code is {outer, inner}
  localparam logic [1:0] CODE_CLR  = 2'b00;
  localparam logic [1:0] CODE_A    = 2'b10;
  localparam logic [1:0] CODE_BOTH = 2'b11;
  localparam logic [1:0] CODE_B    = 2'b01;

endpackage

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - per-sensor synchroniser; SENSOR_DEBOUNCE_EN adds a debounce filter
module sensor_conditioner #(
  parameter int SYNC_STAGES = 2
`ifdef SENSOR_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef SENSOR_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             level;

  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign clean_out = level;
`else
  assign clean_out = synced;
`endif

endmodule

// File: rtl/parking_gate_sensor.sv
// rtl/parking_gate_sensor.sv - gate crossing FSM emitting incr/decr/fault pulses
// SENSOR_DEBOUNCE_EN: enables the debounce filter (and DEBOUNCE_CYCLES) in each sensor path
module parking_gate_sensor
  import parking_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef SENSOR_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic incr,
  output logic decr,
  output logic fault,
  output logic busy
);

  logic        a_clean;
  logic        b_clean;
  logic [1:0]  ab;
  gate_state_t state;
  gate_state_t next_state;
  logic        incr_next;
  logic        decr_next;
  logic        fault_next;

  sensor_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef SENSOR_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
  ) u_cond_a (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (sensor_a),
    .clean_out(a_clean)
  );

  sensor_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef SENSOR_DEBOUNCE_EN
    , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
  ) u_cond_b (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (sensor_b),
    .clean_out(b_clean)
  );

  assign ab = {a_clean, b_clean};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      incr  <= 1'b0;
      decr  <= 1'b0;
      fault <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      incr  <= incr_next;
      decr  <= decr_next;
      fault <= fault_next;
      busy  <= (next_state != IDLE);
    end
  end

  // Any code not listed for a state is that state's own code and holds it
  always_comb begin
    next_state = state;
    incr_next  = 1'b0;
    decr_next  = 1'b0;
    fault_next = 1'b0;
    case (state)
      IDLE: begin
        case (ab)
          CODE_A:    next_state = EN1;
          CODE_B:    next_state = EX1;
          CODE_BOTH: begin next_state = ERR; fault_next = 1'b1; end
          default:   next_state = IDLE;
        endcase
      end
      EN1: begin
        case (ab)
          CODE_BOTH: next_state = EN2;
          CODE_CLR:  next_state = IDLE;
          CODE_B:    begin next_state = ERR; fault_next = 1'b1; end
          default:   next_state = EN1;
        endcase
      end
      EN2: begin
        case (ab)
          CODE_B:   next_state = EN3;
          CODE_A:   next_state = EN1;
          CODE_CLR: begin next_state = ERR; fault_next = 1'b1; end
          default:  next_state = EN2;
        endcase
      end
      EN3: begin
        case (ab)
          CODE_CLR:  begin next_state = IDLE; incr_next = 1'b1; end
          CODE_BOTH: next_state = EN2;
          CODE_A:    begin next_state = ERR; fault_next = 1'b1; end
          default:   next_state = EN3;
        endcase
      end
      EX1: begin
        case (ab)
          CODE_BOTH: next_state = EX2;
          CODE_CLR:  next_state = IDLE;
          CODE_A:    begin next_state = ERR; fault_next = 1'b1; end
          default:   next_state = EX1;
        endcase
      end
      EX2: begin
        case (ab)
          CODE_A:   next_state = EX3;
          CODE_B:   next_state = EX1;
          CODE_CLR: begin next_state = ERR; fault_next = 1'b1; end
          default:  next_state = EX2;
        endcase
      end
      EX3: begin
        case (ab)
          CODE_CLR:  begin next_state = IDLE; decr_next = 1'b1; end
          CODE_BOTH: next_state = EX2;
          CODE_B:    begin next_state = ERR; fault_next = 1'b1; end
          default:   next_state = EX3;
        endcase
      end
      ERR: begin
        if (ab == CODE_CLR) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
